// File: rtl/note_detect.sv
// Tone receiver: measures the half-period of a square wave and decodes it to a 4-bit note code.
// Locks after MATCH_CNT consistent half-periods and reports rest (15) after TIMEOUT silent cycles.
module note_detect #(
  parameter int unsigned TOL       = 4,
  parameter int unsigned MATCH_CNT = 4,
  parameter int unsigned TIMEOUT   = 4000,
  parameter int unsigned CNT_W     = 12
) (
  input  logic       CLK_1M,
  input  logic       RESET,
  input  logic       TONE_IN,
  output logic [3:0] NOTE_OUT,
  output logic       NOTE_VALID,
  output logic       NOTE_STROBE
);

  localparam int unsigned      MC_W  = $clog2(MATCH_CNT + 1);
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(TIMEOUT);
  localparam logic [3:0]       REST  = 4'hF;
  localparam int unsigned T_HALF [15] = '{1912, 1704, 1518, 1277, 1137, 957, 852, 759,
                                          717, 639, 569, 507, 479, 452, 427};

  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_p, r_h;
  logic             r_ev;
  state_t           r_state, w_state_nx;
  logic [3:0]       r_cand, w_cand_nx;
  logic [MC_W-1:0]  r_cnt, w_cnt_nx;
  logic [3:0]       r_note, w_note_nx;
  logic             r_valid, w_valid_nx;
  logic             r_strobe, w_strobe_nx;
  logic             w_edge, w_timeout, w_match;
  logic [3:0]       w_code;
  logic [31:0]      w_h;

  assign w_edge    = r_s2 ^ r_s3;
  assign w_timeout = (r_p == P_MAX) && !w_edge;
  assign w_h       = 32'(r_h);

  // NOTE: all sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the clock edge, independent of statement order.
  always_ff @(posedge CLK_1M) begin
    if (RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_p  <= '0;
      r_h  <= '0;
      r_ev <= 1'b0;
    end else begin
      r_s1 <= TONE_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_ev <= w_edge;
      if (w_edge) begin
        r_h <= r_p;
        r_p <= CNT_W'(1);
      end else if (r_p != P_MAX) begin
        r_p <= r_p + CNT_W'(1);
      end
    end
  end

  // The latched half-period is classified one cycle after its edge; lowest code wins.
  always_comb begin
    w_match = 1'b0;
    w_code  = 4'd0;
    for (int k = 14; k >= 0; k--) begin
      if ((w_h + TOL >= T_HALF[k]) && (w_h <= T_HALF[k] + TOL)) begin
        w_match = 1'b1;
        w_code  = 4'(k);
      end
    end
  end

  always_ff @(posedge CLK_1M) begin
    if (RESET) begin
      r_state  <= SILENT;
      r_cand   <= 4'd0;
      r_cnt    <= '0;
      r_note   <= REST;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cand   <= w_cand_nx;
      r_cnt    <= w_cnt_nx;
      r_note   <= w_note_nx;
      r_valid  <= w_valid_nx;
      r_strobe <= w_strobe_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx  = r_state;
    w_cand_nx   = r_cand;
    w_cnt_nx    = r_cnt;
    w_note_nx   = r_note;
    w_valid_nx  = r_valid;
    w_strobe_nx = 1'b0;
    if (w_timeout) begin
      w_state_nx  = SILENT;
      w_note_nx   = REST;
      w_valid_nx  = 1'b1;
      w_strobe_nx = (r_note != REST) || !r_valid;
    end else if (r_ev) begin
      unique case (r_state)
        SILENT: begin
          w_state_nx = ACQUIRE;
          w_cnt_nx   = '0;
        end
        ACQUIRE: begin
          if (!w_match) begin
            w_cnt_nx = '0;
          end else if (w_code == r_cand) begin
            w_cnt_nx = r_cnt + MC_W'(1);
          end else begin
            w_cand_nx = w_code;
            w_cnt_nx  = MC_W'(1);
          end
          if (w_cnt_nx == MC_W'(MATCH_CNT)) begin
            w_state_nx  = LOCKED;
            w_note_nx   = w_cand_nx;
            w_valid_nx  = 1'b1;
            w_strobe_nx = 1'b1;
          end
        end
        LOCKED: begin
          if (!(w_match && (w_code == r_note))) begin
            w_state_nx = ACQUIRE;
            w_valid_nx = 1'b0;
            w_cand_nx  = w_match ? w_code : r_cand;
            w_cnt_nx   = w_match ? MC_W'(1) : '0;
          end
        end
        default: w_state_nx = SILENT;
      endcase
    end
  end

  assign NOTE_OUT    = r_note;
  assign NOTE_VALID  = r_valid;
  assign NOTE_STROBE = r_strobe;

endmodule

// File: tb/tb_note_detect.sv
// Self-checking bench for note_detect: scenario tasks plus randomized tone trains,
// checked against an event-level model of lock/unlock/timeout behaviour.
`timescale 1ns/1ps
module tb_note_detect;

  localparam int TOL       = 4;
  localparam int MATCH_CNT = 4;
  localparam int TIMEOUT   = 4000;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       tone = 1'b0;
  logic [3:0] note_out;
  logic       valid;
  logic       strobe;

  always #500 clk = ~clk;

  note_detect #(
    .TOL(TOL), .MATCH_CNT(MATCH_CNT), .TIMEOUT(TIMEOUT), .CNT_W(12)
  ) dut (
    .CLK_1M(clk), .RESET(rst), .TONE_IN(tone),
    .NOTE_OUT(note_out), .NOTE_VALID(valid), .NOTE_STROBE(strobe)
  );

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;
  bit prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (strobe === 1'b1) strobe_cnt++;
    if (strobe === 1'b1 && prev_strobe) begin
      miscompares++;
      $display("FAIL strobe_consecutive: strobe high on two cycles in a row at %0t", $time);
    end
    prev_strobe = (strobe === 1'b1);
  end

  initial begin
    #150_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (event level) ----------------
  int half_tab [15] = '{1912, 1704, 1518, 1277, 1137, 957, 852, 759,
                        717, 639, 569, 507, 479, 452, 427};
  bit m_started;      // an edge has been seen since reset / silence
  bit m_locked;
  int m_note;
  bit m_valid;
  int m_strobes = 0;
  int hist[$];        // classifications since acquisition (re)started
  int last_d;         // cycles since the previous transition

  function automatic int classify(int h);
    for (int k = 0; k < 15; k++)
      if (h - half_tab[k] <= TOL && half_tab[k] - h <= TOL) return k;
    return -1;
  endfunction

  function automatic bit run_complete();
    int n = hist.size();
    if (n < MATCH_CNT) return 1'b0;
    for (int i = n - MATCH_CNT; i < n; i++)
      if (hist[i] < 0 || hist[i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_locked  = 1'b0;
    m_note    = 15;
    m_valid   = 1'b0;
    hist.delete();
    last_d    = 0;
  endtask

  task automatic model_timeout();
    if (m_note != 15 || !m_valid) m_strobes++;
    m_note    = 15;
    m_valid   = 1'b1;
    m_locked  = 1'b0;
    m_started = 1'b0;
  endtask

  task automatic model_edge(int h);
    int k = classify(h);
    if (!m_started) begin
      m_started = 1'b1;
      hist.delete();
      return;
    end
    if (m_locked) begin
      if (k == m_note) return;
      m_locked = 1'b0;
      m_valid  = 1'b0;
      hist.delete();
    end
    hist.push_back(k);
    if (run_complete()) begin
      m_locked = 1'b1;
      m_note   = hist[hist.size()-1];
      m_valid  = 1'b1;
      m_strobes++;
      hist.delete();
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst  = 1'b1;
    tone = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    model_reset();
  endtask

  task automatic wait_cycles(int d);
    repeat (d) @(posedge clk);
    #1;
    last_d += d;
  endtask

  // Compare settled outputs against the model, then make the next transition.
  task automatic edge_now(string tag);
    if (last_d > TIMEOUT) model_timeout();
    vectors += 3;
    if (note_out !== 4'(m_note)) begin
      miscompares++;
      $display("FAIL %s note: got %0d want %0d", tag, note_out, m_note);
    end
    if (valid !== m_valid) begin
      miscompares++;
      $display("FAIL %s valid: got %b want %b", tag, valid, m_valid);
    end
    if (strobe_cnt != m_strobes) begin
      miscompares++;
      $display("FAIL %s strobes: got %0d want %0d", tag, strobe_cnt, m_strobes);
    end
    tone = ~tone;
    model_edge(last_d);
    last_d = 0;
  endtask

  task automatic apply_half(string tag, int d);
    edge_now(tag);
    wait_cycles(d);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vectors += 3;
    if (note_out !== 4'hF) begin miscompares++; $display("FAIL reset_note: got %0d want 15", note_out); end
    if (valid !== 1'b0)    begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (strobe !== 1'b0)   begin miscompares++; $display("FAIL reset_strobe: got %b want 0", strobe); end
  endtask

  task automatic test_first_lock();
    do_reset();
    for (int i = 0; i < 4; i++) apply_half("lock0", 1912);
    edge_now("lock0_5th");
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL lock_early: valid got %b want 0", valid); end
    @(posedge clk); #1;
    vectors += 3;
    if (valid !== 1'b1)    begin miscompares++; $display("FAIL lock_valid: got %b want 1", valid); end
    if (note_out !== 4'd0) begin miscompares++; $display("FAIL lock_note: got %0d want 0", note_out); end
    if (strobe !== 1'b1)   begin miscompares++; $display("FAIL lock_strobe: got %b want 1", strobe); end
    @(posedge clk); #1;
    vectors++;
    if (strobe !== 1'b0) begin miscompares++; $display("FAIL lock_strobe_width: got %b want 0", strobe); end
    last_d += 5;
    wait_cycles(1912 - 5);
    for (int i = 0; i < 2; i++) apply_half("lock0_hold", 1912);
    edge_now("lock0_end");
  endtask

  task automatic test_tolerance();
    do_reset();
    for (int i = 0; i < 6; i++) apply_half("tol_431", 431);
    edge_now("tol_431_end");
    do_reset();
    for (int i = 0; i < 7; i++) apply_half("tol_432", 432);
    edge_now("tol_432_end");
  endtask

  task automatic test_timeout();
    int seen = -1;
    do_reset();
    for (int i = 0; i < 6; i++) apply_half("to_lock5", 957);
    edge_now("to_last_edge");
    wait_cycles(4001);
    vectors += 2;
    if (note_out !== 4'd5) begin miscompares++; $display("FAIL timeout_early_note: got %0d want 5", note_out); end
    if (valid !== 1'b1)    begin miscompares++; $display("FAIL timeout_early_valid: got %b want 1", valid); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (strobe === 1'b1 && seen < 0) seen = c;
    end
    last_d += 4;
    vectors += 3;
    if (seen < 0 || seen > 2) begin
      miscompares++;
      $display("FAIL timeout_strobe_time: strobe offset got %0d want 0..2", seen);
    end
    if (note_out !== 4'hF) begin miscompares++; $display("FAIL timeout_note: got %0d want 15", note_out); end
    if (valid !== 1'b1)    begin miscompares++; $display("FAIL timeout_valid: got %b want 1", valid); end
    wait_cycles(600);
    edge_now("to_after");
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 6; i++) apply_half("gl_lock3", 1277);
    apply_half("gl_pre", 1000);
    apply_half("gl_hit", 1277);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_drop: valid got %b want 0", valid); end
    for (int i = 0; i < 4; i++) apply_half("gl_relock", 1277);
    edge_now("gl_end");
  endtask

  task automatic test_reset_mid_acquire();
    do_reset();
    for (int i = 0; i < 4; i++) apply_half("rm_acq", 507);
    do_reset();
    vectors += 2;
    if (note_out !== 4'hF) begin miscompares++; $display("FAIL rm_note: got %0d want 15", note_out); end
    if (valid !== 1'b0)    begin miscompares++; $display("FAIL rm_valid: got %b want 0", valid); end
    for (int i = 0; i < 4; i++) apply_half("rm_restart", 507);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL rm_four_edges: valid got %b want 0", valid); end
    apply_half("rm_fifth", 507);
    edge_now("rm_end");
  endtask

  task automatic test_boundary_gap();
    do_reset();
    for (int i = 0; i < 6; i++) apply_half("bg_lock14", 427);
    edge_now("bg_last");
    wait_cycles(TIMEOUT);
    edge_now("bg_gap");
    wait_cycles(427);
    edge_now("bg_end");
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int k = int'($urandom_range(14, 8));
      int n = int'($urandom_range(6, 3));
      for (int i = 0; i < n; i++) begin
        int dev;
        if ($urandom_range(5, 0) == 0)
          dev = (TOL + 1 + int'($urandom_range(3, 0))) * (($urandom_range(1, 0) == 0) ? 1 : -1);
        else
          dev = int'($urandom_range(2 * TOL, 0)) - TOL;
        apply_half("rand", half_tab[k] + dev);
      end
      if ($urandom_range(2, 0) == 0) apply_half("rand_glitch", int'($urandom_range(900, 300)));
    end
    edge_now("rand_end");
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_tolerance();
    test_timeout();
    test_glitch();
    test_reset_mid_acquire();
    test_boundary_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
